// File: rtl/uart_pkg.sv
// Shared types and limits for the UART transmitter.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned MaxDataWidth  = 9;
    localparam int unsigned MaxOversample = 16;

    // Counters are sized for the largest legal configuration.
    localparam int unsigned TickCntW = $clog2(MaxOversample);
    localparam int unsigned BitCntW  = $clog2(MaxDataWidth);

    typedef enum logic [2:0] {
        Idle,
        Start,
        Data,
        Parity,
        Stop
    } uart_tx_state_e;

    typedef enum logic [1:0] {
        None = 2'b00,
        Even = 2'b01,
        Odd  = 2'b10
    } parity_mode_e;

    // Mode 2'b11 is treated as no parity.
    function automatic parity_mode_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return Even;
            2'b10:   return Odd;
            default: return None;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; a push alongside a pop is accepted when full.
module uart_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned LevelW = PtrW + 1;

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] level_q, level_d;
    logic              do_push, do_pop;

    assign full_o  = (level_q == LevelW'(Depth));
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LevelW'(1);
            2'b01:   level_d = level_q - LevelW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO feeding a start/data/[parity]/stop serialiser.
// Define UART_TX_PARITY_EN to build the parity bit; otherwise parity_i is ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned Oversample = 16,
    parameter int unsigned FifoDepth  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        tick_i,
    input  logic                        valid_i,
    input  logic [DataWidth-1:0]        data_i,
    output logic                        ready_o,
    input  logic [1:0]                  parity_i,
    input  logic                        stop2_i,
    output logic                        txd_o,
    output logic                        busy_o,
    output logic [$clog2(FifoDepth):0]  level_o
);

    uart_tx_state_e       state_q, state_d;
    logic [TickCntW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic                 stop2_q, stop2_d;
    logic                 txd_q, txd_d;
    logic [DataWidth-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic                 load, bit_done;
`ifdef UART_TX_PARITY_EN
    parity_mode_e         par_mode_q, par_mode_d;
    logic                 par_q, par_d;
`else
    logic                 unused_parity;
    assign unused_parity = ^parity_i;
`endif

    uart_fifo #(
        .Width (DataWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (valid_i && ready_o),
        .wdata_i (data_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign ready_o  = !fifo_full;
    assign busy_o   = (state_q != Idle) || !fifo_empty;
    assign txd_o    = txd_q;
    assign bit_done = tick_i && (tick_cnt_q == TickCntW'(Oversample - 1));

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop2_d    = stop2_q;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        txd_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_mode_d = par_mode_q;
        par_d      = par_q;
`endif

        if (state_q != Idle && tick_i) begin
            tick_cnt_d = bit_done ? '0 : tick_cnt_q + TickCntW'(1);
        end

        case (state_q)
            Idle: load = !fifo_empty;
            Start: if (bit_done) state_d = Data;
            Data: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BitCntW'(DataWidth - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = (par_mode_q != None) ? Parity : Stop;
`else
                        state_d = Stop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            Parity: if (bit_done) state_d = Stop;
`endif
            Stop: begin
                // bit_cnt counts stop bits; a queued byte starts with no idle gap.
                if (bit_done) begin
                    if (stop2_q && bit_cnt_q == '0) begin
                        bit_cnt_d = BitCntW'(1);
                    end else begin
                        state_d = Idle;
                        load    = !fifo_empty;
                    end
                end
            end
            default: state_d = Idle;
        endcase

        if (load) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_rdata;
            stop2_d    = stop2_i;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = Start;
`ifdef UART_TX_PARITY_EN
            par_mode_d = decode_parity(parity_i);
            par_d      = ^fifo_rdata;
`endif
        end

        // Line level follows the state being entered so txd_o stays registered.
        case (state_d)
            Start:   txd_d = 1'b0;
            Data:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            Parity:  txd_d = par_d ^ (par_mode_d == Odd);
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= Idle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_mode_q <= None;
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            stop2_q    <= stop2_d;
            txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_mode_q <= par_mode_d;
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected frames are queued at write time, a line monitor checks them.
module tb_uart_tx_fifo;

    logic       clk_i    = 1'b0;
    logic       rst_ni   = 1'b0;
    logic       tick_i   = 1'b1;
    logic       valid_i  = 1'b0;
    logic [7:0] data_i   = 8'h00;
    logic [1:0] parity_i = 2'b00;
    logic       stop2_i  = 1'b0;
    logic       ready_o, txd_o, busy_o;
    logic [2:0] level_o;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    frame_t exp_q[$];
    int     start_cyc_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     frames_started = 0;
    int     frames_done    = 0;
    int     cyc = 0;
    int     last_end_cyc = 0;

    uart_tx_fifo #(
        .DataWidth  (8),
        .Oversample (16),
        .FifoDepth  (4)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tick_i   (tick_i),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .parity_i (parity_i),
        .stop2_i  (stop2_i),
        .txd_o    (txd_o),
        .busy_o   (busy_o),
        .level_o  (level_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] par, input logic s2);
        frame_t     f;
        logic [1:0] eff = par;
`ifndef UART_TX_PARITY_EN
        eff = 2'b00;
`endif
        f.bits = '0;
        for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
        f.len = 9;
        if (eff == 2'b01) begin f.bits[f.len] = ^d;  f.len++; end
        if (eff == 2'b10) begin f.bits[f.len] = ~^d; f.len++; end
        f.bits[f.len] = 1'b1; f.len++;
        if (s2) begin f.bits[f.len] = 1'b1; f.len++; end
        return f;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic write_frame(input logic [7:0] d, input frame_t f);
        @(negedge clk_i);
        check("write_ready", int'(ready_o), 1);
        data_i  = d;
        valid_i = 1'b1;
        exp_q.push_back(f);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int b = 0;
        while (frames_done < target && b < budget) begin
            @(negedge clk_i); #1; b++;
        end
        check("frames_done", frames_done, target);
    endtask

    task automatic wait_start(input int target, input int budget);
        int b = 0;
        while (frames_started < target && b < budget) begin
            @(negedge clk_i); #1; b++;
        end
        check("frames_started", frames_started, target);
    endtask

    // Line monitor: every bit must hold its expected level for all 16 clocks.
    frame_t cur;
    logic   in_frame = 1'b0;
    logic   bit_bad  = 1'b0;
    logic   bad_val  = 1'b0;
    int     samp     = 0;

    initial begin : monitor
        int idx;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && txd_o == 1'b0) begin
                    n_tests++;
                    frames_started++;
                    start_cyc_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_start: txd low with no frame queued (t=%0t)", $time);
                    end else begin
                        cur      = exp_q.pop_front();
                        in_frame = 1'b1;
                        samp     = 0;
                        bit_bad  = 1'b0;
                    end
                end
                if (in_frame) begin
                    idx = samp / 16;
                    if (txd_o !== cur.bits[idx] && !bit_bad) begin
                        bit_bad = 1'b1;
                        bad_val = txd_o;
                    end
                    if (samp % 16 == 15) begin
                        n_tests++;
                        if (bit_bad) begin
                            n_fail++;
                            $display("FAIL frame%0d_bit%0d: txd %b required %b", frames_started, idx, bad_val, cur.bits[idx]);
                        end
                        bit_bad = 1'b0;
                        if (idx == cur.len - 1) begin
                            in_frame = 1'b0;
                            frames_done++;
                            last_end_cyc = cyc;
                        end
                    end
                    samp++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        frame_t f;
        int     accepted;
        int     base;
        int     low_cnt;

        repeat (3) @(negedge clk_i);
        check("rst_txd",   int'(txd_o),   1);
        check("rst_busy",  int'(busy_o),  0);
        check("rst_ready", int'(ready_o), 1);
        check("rst_level", int'(level_o), 0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
        f = '{bits: 16'h034A, len: 10};
        write_frame(8'hA5, f);
        @(negedge clk_i);
        check("a5_level", int'(level_o), 1);
        check("a5_busy",  int'(busy_o),  1);
        wait_done(1, 400);
        @(negedge clk_i);
        check("a5_idle_busy", int'(busy_o), 0);

        // 0x07 even parity, two stops
        parity_i = 2'b01; stop2_i = 1'b1;
`ifdef UART_TX_PARITY_EN
        f = '{bits: 16'h0E0E, len: 12};
`else
        f = '{bits: 16'h060E, len: 11};
`endif
        write_frame(8'h07, f);
        wait_done(2, 400);

        // 0x00 odd parity -> parity bit 1
        parity_i = 2'b10; stop2_i = 1'b0;
`ifdef UART_TX_PARITY_EN
        f = '{bits: 16'h0600, len: 11};
`else
        f = '{bits: 16'h0200, len: 10};
`endif
        write_frame(8'h00, f);
        wait_done(3, 400);

        // mode 11 behaves as no parity
        parity_i = 2'b11;
        f = '{bits: 16'h0278, len: 10};
        write_frame(8'h3C, f);
        wait_done(4, 400);

        // Burst: hold valid until the FIFO fills, then all frames go out back to back
        parity_i = 2'b00; stop2_i = 1'b0;
        repeat (3) @(negedge clk_i);
        start_cyc_q.delete();
        base     = frames_done;
        accepted = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            if (!ready_o) break;
            data_i  = 8'(8'h11 * (accepted + 1));
            valid_i = 1'b1;
            exp_q.push_back(make_frame(data_i, 2'b00, 1'b0));
            accepted++;
        end
        data_i = 8'h99;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        check("burst_accepted", accepted, 5);
        @(negedge clk_i);
        check("burst_full_level", int'(level_o), 4);
        check("burst_ready_low",  int'(ready_o), 0);
        wait_done(base + 5, 1500);
        if (start_cyc_q.size() > 0) check("burst_span", last_end_cyc - start_cyc_q[0] + 1, 800);
        else check("burst_span", 0, 800);
        @(negedge clk_i);
        check("burst_busy",  int'(busy_o),  0);
        check("burst_level", int'(level_o), 0);

        // Mode change mid-frame applies to the following frame only
        parity_i = 2'b01; stop2_i = 1'b1;
        base = frames_started;
        write_frame(8'h07, make_frame(8'h07, 2'b01, 1'b1));
        wait_start(base + 1, 100);
        repeat (40) @(negedge clk_i);
        parity_i = 2'b10; stop2_i = 1'b0;
        base = frames_done;
        write_frame(8'h07, make_frame(8'h07, 2'b10, 1'b0));
        wait_done(base + 2, 800);

        // Reset during data bit 3 (0x55 bit3 is 0), with a second byte queued
        parity_i = 2'b00; stop2_i = 1'b0;
        repeat (3) @(negedge clk_i);
        base = frames_started;
        write_frame(8'h55, make_frame(8'h55, 2'b00, 1'b0));
        write_frame(8'h3C, make_frame(8'h3C, 2'b00, 1'b0));
        wait_start(base + 1, 100);
        repeat (66) @(negedge clk_i);
        check("pre_rst_txd", int'(txd_o), 0);
        #1 rst_ni = 1'b0;
        #1;
        check("mid_rst_txd",   int'(txd_o),   1);
        check("mid_rst_level", int'(level_o), 0);
        check("mid_rst_busy",  int'(busy_o),  0);
        exp_q.delete();
        @(posedge clk_i);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        low_cnt = 0;
        repeat (300) begin
            @(negedge clk_i);
            if (txd_o !== 1'b1) low_cnt++;
        end
        check("post_rst_no_frame", low_cnt, 0);
        check("post_rst_busy",  int'(busy_o),  0);
        check("post_rst_ready", int'(ready_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DataWidth, default 8, payload bits per frame; legal range 5..9.
REQ-002 Parameter Oversample, default 16, tick_i strobes per bit period; legal range 1..16.
REQ-003 Parameter FifoDepth, default 4, transmit FIFO entries; power of two, 2..32.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk_i  in  1  clock; all state on rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 tick_i  in  1  single-cycle baud×Oversample strobe.
REQ-008 valid_i  in  1  write request, data_i valid.
REQ-009 data_i  in  DataWidth  payload.
REQ-010 ready_o  out  1  FIFO not full.
REQ-011 parity_i  in  2  parity mode: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-012 stop2_i  in  1  1 = two stop bits, 0 = one stop bit.
REQ-013 txd_o  out  1  serial line, registered, idle high.
REQ-014 busy_o  out  1  frame in progress or FIFO non-empty.
REQ-015 level_o  out  $clog2(FifoDepth)+1  FIFO occupancy.

Function
REQ-016 A write SHALL occur when valid_i && ready_o; valid_i with ready_o low SHALL be ignored and the FIFO left unchanged.
REQ-017 FSM states: Idle, Start, Data, Parity, Stop.
REQ-018 Idle with a non-empty FIFO SHALL pop one entry, latch parity_i and stop2_i, clear the tick and bit counters, and enter Start; txd_o goes low on the next clock edge.
REQ-019 Every bit SHALL last exactly Oversample tick_i strobes; a state advances on the clock edge that registers its Oversample-th tick.
REQ-020 Start drives 0, then Data.
REQ-021 Data drives payload bits LSB first, DataWidth bits, then Parity if the latched mode is even or odd, else Stop.
REQ-022 Parity drives XOR of the payload (even) or its inverse (odd), then Stop.
REQ-023 Stop drives 1 for one bit period, or two if stop2 is latched, then Idle.
REQ-024 An Idle→Start transition SHALL occur in the same cycle as Stop→Idle completion only if the FIFO is non-empty; back-to-back frames therefore carry no extra idle gap.
REQ-025 Changes to parity_i or stop2_i mid-frame SHALL NOT affect the current frame.
REQ-026 A simultaneous push and pop SHALL leave level_o unchanged and is legal when full.
REQ-027 tick_i SHALL be ignored in Idle; the tick counter is cleared on frame start.
REQ-028 busy_o SHALL be 1 whenever the state is not Idle or level_o is non-zero.

Reset
REQ-029 While rst_ni is low: txd_o=1, busy_o=0, ready_o=1, level_o=0, state=Idle, all counters and pointers 0, FIFO contents discarded.
REQ-030 Reset asserted mid-frame SHALL return txd_o high asynchronously, with no partial stop bit.

Configuration
REQ-031 Macro UART_TX_PARITY_EN: when defined, parity behaves as in REQ-011 and REQ-022; when undefined, the Parity state, parity logic, and latch SHALL be absent, parity_i remains a port but is ignored, and frames never carry a parity bit.

Structure
REQ-032 Package uart_pkg SHALL hold the uart_tx_state_e enum, the parity_mode_e typedef (None, Even, Odd), and the constants MaxDataWidth=9 and MaxOversample=16.
REQ-033 Sub-module uart_fifo (parametrised width/depth, synchronous FIFO, full/empty/level) SHALL hold the buffer; the FSM and shifter stay in uart_tx_fifo.

Verification
REQ-034 Bench setup: DataWidth=8, Oversample=16, tick every clock; parity 00, stop2 0; write 0xA5 → txd sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 clocks; then busy_o=0.
REQ-035 Macro defined, parity 01, stop2 1; write 0x07 → data bits then parity 1, then 32 clocks high.
REQ-036 Parity 10 with payload 0x00 → parity bit 1; parity 11 → no parity bit, frame is 10 bits.
REQ-037 Hold valid_i high with FifoDepth=4 → ready_o falls after 5 accepted writes (1 popped + 4 buffered); all 5 bytes are sent back-to-back with no idle gap between stop and start.
REQ-038 Drop rst_ni for one cycle during Data bit 3 → txd_o=1 immediately, level_o=0, no further frame starts.
REQ-039 Toggle parity_i mid-frame → the current frame uses the latched mode, and the next frame uses the new mode.
